day2_range_dispatcher: RTL
==========================

// Module: day2_range_dispatcher
// PURPOSE
//   Upstream controller for the day-2 ID-search array. Accepts a valid/ready stream of
//   parsed ID ranges, packs them into batches of NUM_UNITS, drives the array's shared
//   load/en and per-unit start/end buses, and sequences batches until the stream ends.
//   Reports the array's final sum once the last batch has drained.
// PARAMETERS
//   W             48  ID width in bits; matches the ID-search array
//   NUM_UNITS     8   parallel ID finders per batch; >= 1
//   SETTLE_CYCLES 6   cycles after load during which pz_done is ignored (array pipeline depth + 1)
//   DRAIN_CYCLES  2   cycles after the final pz_done before pz_id_sum is sampled (gatherer latency + 1)
// PORTS
//   clock        in   1               system clock, rising edge
//   reset        in   1               synchronous, active-high; array shares the same reset
//   s_valid      in   1               range beat valid
//   s_ready      out  1               dispatcher accepts a beat this cycle
//   s_start      in   W               first ID of range
//   s_end        in   W               last ID of range (inclusive)
//   s_last       in   1               beat is the final range of the puzzle input
//   pz_load      out  1               one-cycle load strobe to array
//   pz_en        out  1               run enable to array
//   pz_start     out  W x NUM_UNITS   per-unit start ID, registered
//   pz_end       out  W x NUM_UNITS   per-unit end ID, registered
//   pz_done      in   1               array: all units out of range
//   pz_id_sum    in   W               array running total
//   result       out  W               final sum; valid when result_valid
//   result_valid out  1               final sum valid; sticky until reset
//   batch_count  out  16              batches launched so far
// BEHAVIOUR
//   Reset (sync, active-high; clock clock): state=FILL, slot index 0, all slots padded
//   (start=1, end=0), s_ready=1, pz_load=0, pz_en=0, result=0, result_valid=0, batch_count=0.
//   Reset mid-operation aborts any batch; no partial result is reported.
//   FILL: s_ready=1; beat accepted when s_valid&s_ready, written into slot[idx], idx++.
//     -> LOAD when idx reaches NUM_UNITS or the accepted beat has s_last (latch last_flag).
//     Unfilled slots keep padding (start=1 > end=0) so those units contribute nothing.
//     s_start > s_end is forwarded unchanged; contributes 0, no error.
//   LOAD (1 cycle): pz_load=1, pz_en=0, s_ready=0; batch_count++ (saturates at 0xFFFF).
//   SETTLE: pz_en=1 for SETTLE_CYCLES cycles; pz_done ignored (stale pipeline flags).
//   RUN: pz_en=1 until pz_done=1 sampled. On that edge:
//     last_flag=0 -> FILL, slots re-padded, idx=0, pz_en=0 next cycle.
//     last_flag=1 -> DRAIN.
//   DRAIN: pz_en=0 for DRAIN_CYCLES cycles, then result<=pz_id_sum, result_valid<=1 -> DONE.
//   DONE: terminal; s_ready=0, pz_en=0, outputs held until reset.
//   pz_start/pz_end change only in FILL; stable from LOAD through end of RUN.
//   Array accumulators are never cleared between batches; result is the cumulative total.
//   s_ready=0 in every state except FILL; beats offered otherwise are held by the source.
//   Beat with s_last arriving exactly as idx reaches NUM_UNITS: single LOAD, last_flag=1.
//   Latency per batch: 1 (LOAD) + SETTLE_CYCLES + run length; result DRAIN_CYCLES+1 after final done.
// TESTING (bench: dispatcher + ID array, W=48, NUM_UNITS=2, PUZZLE=1)
//   Ranges 11-22, 95-115, 998-1012(last) -> 2 batches, batch_count=2, result=1142.
//   Single range 11-22 with s_last -> slot1 padded, 1 batch, result=33.
//   Ranges 95-115, 11-22(last) exactly fill batch -> 1 batch, result=132.
//   Range 50-10 (start>end, last) -> RUN exits after SETTLE, result=0, result_valid=1.
//   s_valid toggled every other cycle during FILL -> same result as back-to-back (1142).
//   Reset asserted mid-RUN of batch 1, then stream 11-22(last) -> result=33, batch_count=1.

Source files
------------

// File: rtl/day2_range_dispatcher.sv
// rtl/day2_range_dispatcher.sv - packs ID ranges into batches for the day-2 ID-search array
// Sequences load/settle/run per batch and captures the array's cumulative sum after the last one.
module day2_range_dispatcher #(
   parameter int W             = 48,
   parameter int NUM_UNITS     = 8,
   parameter int SETTLE_CYCLES = 6,
   parameter int DRAIN_CYCLES  = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [W-1:0]           s_start,
   input  logic [W-1:0]           s_end,
   input  logic                   s_last,
   output logic                   pz_load,
   output logic                   pz_en,
   output logic [W*NUM_UNITS-1:0] pz_start,
   output logic [W*NUM_UNITS-1:0] pz_end,
   input  logic                   pz_done,
   input  logic [W-1:0]           pz_id_sum,
   output logic [W-1:0]           result,
   output logic                   result_valid,
   output logic [15:0]            batch_count
);

   localparam int IW = $clog2(NUM_UNITS + 1);
   localparam int TW = 16;
   // Padding makes start > end so an unused unit finds nothing.
   localparam logic [W-1:0] PAD_START = W'(1);
   localparam logic [W-1:0] PAD_END   = '0;

   typedef enum logic [2:0] {
      FILL,
      LOAD,
      SETTLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

   state_t         state;
   state_t         state_next;
   logic [IW-1:0]  idx;
   logic           last_flag;
   logic [TW-1:0]  timer;
   logic           accept;

   always_comb begin
      state_next = state;
      s_ready    = 1'b0;
      pz_load    = 1'b0;
      pz_en      = 1'b0;
      accept     = 1'b0;
      case (state)
         FILL: begin
            s_ready = 1'b1;
            accept  = s_valid;
            if (s_valid && (idx == IW'(NUM_UNITS - 1) || s_last)) begin
               state_next = LOAD;
            end
         end
         LOAD: begin
            pz_load    = 1'b1;
            state_next = SETTLE;
         end
         SETTLE: begin
            // Done flags still reflect the previous batch while the array pipeline refills.
            pz_en = 1'b1;
            if (timer == TW'(SETTLE_CYCLES - 1)) begin
               state_next = RUN;
            end
         end
         RUN: begin
            pz_en = 1'b1;
            if (pz_done) begin
               state_next = last_flag ? DRAIN : FILL;
            end
         end
         DRAIN: begin
            if (timer == TW'(DRAIN_CYCLES - 1)) begin
               state_next = DONE;
            end
         end
         DONE: begin
         end
         default: begin
            state_next = FILL;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= FILL;
         idx          <= '0;
         last_flag    <= 1'b0;
         timer        <= '0;
         pz_start     <= {NUM_UNITS{PAD_START}};
         pz_end       <= {NUM_UNITS{PAD_END}};
         result       <= '0;
         result_valid <= 1'b0;
         batch_count  <= '0;
      end else begin
         state <= state_next;
         timer <= (state_next != state) ? '0 : timer + TW'(1);

         if (accept) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
               if (idx == IW'(i)) begin
                  pz_start[i*W +: W] <= s_start;
                  pz_end[i*W +: W]   <= s_end;
               end
            end
            idx <= idx + IW'(1);
            if (s_last) begin
               last_flag <= 1'b1;
            end
         end

         if (state == LOAD && batch_count != 16'hFFFF) begin
            batch_count <= batch_count + 16'd1;
         end

         // Slots are re-padded only as RUN hands back to FILL, keeping them stable while the array runs.
         if (state == RUN && pz_done && !last_flag) begin
            pz_start <= {NUM_UNITS{PAD_START}};
            pz_end   <= {NUM_UNITS{PAD_END}};
            idx      <= '0;
         end

         if (state == DRAIN && state_next == DONE) begin
            result       <= pz_id_sum;
            result_valid <= 1'b1;
         end
      end
   end

endmodule
